// File: rtl/mem_responder.sv
// mem_responder: 256-byte synchronous RAM behind the MFA/MFC memory handshake.
// A request is latched when MFA is seen high in IDLE. The responder then waits
// WAIT_CYCLES extra cycles, performs the access and raises MFC, which it holds
// until MFA is released.
//
// Handshake: the initiator raises MFA with READ_WRITE/WORD_BYTE/MEMADD/DataIn
// valid and keeps MFA high until it sees MFC. MFC stays high, and DataOut is
// stable, until the first edge at which MFA is sampled low. Dropping MFA before
// MFC aborts the request without touching memory or DataOut.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        READ_WRITE,
  input  logic        WORD_BYTE,
  input  logic [7:0]  MEMADD,
  input  logic [31:0] DataIn,
  output logic        MFC,
  output logic [31:0] DataOut,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;

  // Request fields captured at acceptance; later input changes are ignored.
  logic        lat_rw;
  logic        lat_wb;
  logic [7:0]  lat_addr;
  logic [31:0] lat_data;

  logic        accept;
  logic        do_access;
  logic        do_dec;

  logic [7:0]  mem [0:255];

  // Byte addresses of the four lanes. Word accesses are forced to the aligned
  // base, so lane addresses never wrap past 0xFF.
  logic [7:0]  a0;
  logic [7:0]  a1;
  logic [7:0]  a2;
  logic [7:0]  a3;
  logic [31:0] rd_data;

  assign a0 = lat_wb ? {lat_addr[7:2], 2'b00} : lat_addr;
  assign a1 = {lat_addr[7:2], 2'b01};
  assign a2 = {lat_addr[7:2], 2'b10};
  assign a3 = {lat_addr[7:2], 2'b11};

  // Little-endian word assembly; a byte read zero-extends.
  always_comb begin
    rd_data = {24'd0, mem[a0]};
    if (lat_wb) begin
      rd_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_access = 1'b0;
    do_dec    = 1'b0;
    case (state)
      S_IDLE: begin
        if (MFA) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!MFA) begin
          state_nxt = S_IDLE;
        end else if (cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = S_DONE;
        end else begin
          do_dec = 1'b1;
        end
      end
      S_DONE: begin
        // Only a low MFA releases DONE, so a held MFA cannot start a new access.
        if (!MFA) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Wait counter and request latches.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt      <= 4'd0;
      lat_rw   <= 1'b0;
      lat_wb   <= 1'b0;
      lat_addr <= 8'd0;
      lat_data <= 32'd0;
    end else if (accept) begin
      cnt      <= WAIT_INIT;
      lat_rw   <= READ_WRITE;
      lat_wb   <= WORD_BYTE;
      lat_addr <= MEMADD;
      lat_data <= DataIn;
    end else if (do_dec) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Memory write port. Storage has no reset; Reset only blocks a commit on
  // the same edge so a write still waiting is cancelled.
  always_ff @(posedge Clk) begin
    if (do_access && !lat_rw && !Reset) begin
      mem[a0] <= lat_data[7:0];
      if (lat_wb) begin
        mem[a1] <= lat_data[15:8];
        mem[a2] <= lat_data[23:16];
        mem[a3] <= lat_data[31:24];
      end
    end
  end

  // Read data register: only a completed read updates it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DataOut <= 32'd0;
    end else if (do_access && lat_rw) begin
      DataOut <= rd_data;
    end
  end

  assign MFC       = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table-driven accesses on a WAIT_CYCLES = 2 instance
// plus hand sequences for abort, reset in WAIT, late input changes, and a
// WAIT_CYCLES = 0 instance for the held-MFA handshake.
module tb_mem_responder;

  localparam int W1 = 2;

  logic        Clk;
  logic        Reset;

  logic        r_mfa;
  logic        r_rw;
  logic        r_wb;
  logic [7:0]  r_addr;
  logic [31:0] r_din;
  logic        r_mfc;
  logic [31:0] r_dout;
  logic [1:0]  r_state;

  logic        z_mfa;
  logic        z_rw;
  logic        z_wb;
  logic [7:0]  z_addr;
  logic [31:0] z_din;
  logic        z_mfc;
  logic [31:0] z_dout;
  logic [1:0]  z_state;

  int passed;
  int total;

  mem_responder #(.WAIT_CYCLES(W1)) dut (
    .Clk(Clk), .Reset(Reset), .MFA(r_mfa), .READ_WRITE(r_rw),
    .WORD_BYTE(r_wb), .MEMADD(r_addr), .DataIn(r_din),
    .MFC(r_mfc), .DataOut(r_dout), .fsm_state(r_state)
  );

  mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .MFA(z_mfa), .READ_WRITE(z_rw),
    .WORD_BYTE(z_wb), .MEMADD(z_addr), .DataIn(z_din),
    .MFC(z_mfc), .DataOut(z_dout), .fsm_state(z_state)
  );

  // Clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rw;
    logic        wb;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got === expv) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, expv);
  endtask

  // Full access on the WAIT_CYCLES = 2 instance: latency, DataOut, MFC release.
  task automatic run_access(input logic rw, input logic wb, input logic [7:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_out,
                            input string tag);
    int lat;
    bit done;
    @(negedge Clk);
    r_rw = rw; r_wb = wb; r_addr = addr; r_din = data; r_mfa = 1'b1;
    lat = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge Clk); #1;
      lat++;
      if (r_mfc) done = 1'b1;
    end
    if (done) check({tag, "_latency"}, 32'(lat - 1), 32'(W1 + 1));
    else check({tag, "_timeout"}, 32'(r_mfc), 32'd1);
    check({tag, "_dout"}, r_dout, exp_out);
    @(negedge Clk);
    r_mfa = 1'b0;
    @(posedge Clk); #1;
    check({tag, "_mfc_fall"}, 32'(r_mfc), 32'd0);
  endtask

  initial begin
    int n;
    bit done;
    passed = 0;
    total  = 0;
    Reset = 1'b1;
    r_mfa = 1'b0; r_rw = 1'b0; r_wb = 1'b0; r_addr = 8'd0; r_din = 32'd0;
    z_mfa = 1'b0; z_rw = 1'b0; z_wb = 1'b0; z_addr = 8'd0; z_din = 32'd0;

    vecs[0]  = '{1'b0, 1'b1, 8'h40, 32'h01020304, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 8'h30, 32'h0BADCAFE, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b1, 8'h10, 32'h00000000, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b0, 8'h12, 32'hAAAAAA55, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b1, 8'h10, 32'h00000000, 32'hDE55BEEF};
    vecs[6]  = '{1'b1, 1'b0, 8'h13, 32'h00000000, 32'h000000DE};
    vecs[7]  = '{1'b0, 1'b1, 8'h21, 32'h11223344, 32'h000000DE};
    vecs[8]  = '{1'b1, 1'b1, 8'h20, 32'h00000000, 32'h11223344};
    vecs[9]  = '{1'b1, 1'b0, 8'h20, 32'h00000000, 32'h00000044};
    vecs[10] = '{1'b1, 1'b1, 8'h23, 32'h00000000, 32'h11223344};
    vecs[11] = '{1'b0, 1'b1, 8'hFC, 32'hAABBCCDD, 32'h11223344};
    vecs[12] = '{1'b1, 1'b1, 8'hFF, 32'h00000000, 32'hAABBCCDD};
    vecs[13] = '{1'b1, 1'b0, 8'hFF, 32'h00000000, 32'h000000AA};
    vecs[14] = '{1'b1, 1'b0, 8'h42, 32'h00000000, 32'h00000002};

    // Reset values
    repeat (3) @(posedge Clk);
    #1;
    check("rst_mfc", 32'(r_mfc), 32'd0);
    check("rst_dout", r_dout, 32'd0);
    check("rst_state", 32'(r_state), 32'd0);
    check("rst0_mfc", 32'(z_mfc), 32'd0);
    check("rst0_dout", z_dout, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Table-driven accesses
    for (int i = 0; i < 15; i++) begin
      run_access(vecs[i].rw, vecs[i].wb, vecs[i].addr, vecs[i].data, vecs[i].exp,
                 $sformatf("vec%0d", i));
    end

    // Abort: drop MFA after one WAIT cycle; 0x40 must keep 0x01020304.
    @(negedge Clk);
    r_rw = 1'b0; r_wb = 1'b1; r_addr = 8'h40; r_din = 32'hFFFFFFFF; r_mfa = 1'b1;
    @(posedge Clk); #1;
    check("abort_in_wait", 32'(r_state), 32'd1);
    @(posedge Clk); #1;
    check("abort_mfc_pre", 32'(r_mfc), 32'd0);
    @(negedge Clk);
    r_mfa = 1'b0;
    @(posedge Clk); #1;
    check("abort_idle", 32'(r_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("abort_mfc", 32'(r_mfc), 32'd0);
      @(posedge Clk); #1;
    end
    check("abort_dout", r_dout, 32'h00000002);
    run_access(1'b1, 1'b1, 8'h40, 32'd0, 32'h01020304, "abort_rd");

    // Inputs changed after acceptance are ignored.
    @(negedge Clk);
    r_rw = 1'b0; r_wb = 1'b1; r_addr = 8'h50; r_din = 32'h12345678; r_mfa = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    r_rw = 1'b1; r_wb = 1'b0; r_addr = 8'h60; r_din = 32'h00000000;
    done = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge Clk); #1;
      n++;
      if (r_mfc) done = 1'b1;
    end
    check("late_chg_done", 32'(done), 32'd1);
    check("late_chg_lat", 32'(n), 32'(W1 + 1));
    check("late_chg_dout", r_dout, 32'h01020304);
    @(negedge Clk);
    r_mfa = 1'b0;
    @(posedge Clk); #1;
    run_access(1'b1, 1'b1, 8'h50, 32'd0, 32'h12345678, "late_chg_rd");

    // Reset while in WAIT cancels a pending write to 0x30.
    @(negedge Clk);
    r_rw = 1'b0; r_wb = 1'b1; r_addr = 8'h30; r_din = 32'hCAFEF00D; r_mfa = 1'b1;
    @(posedge Clk); #1;
    check("rstw_in_wait", 32'(r_state), 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    r_mfa = 1'b0;
    @(posedge Clk); #1;
    check("rstw_mfc", 32'(r_mfc), 32'd0);
    check("rstw_dout", r_dout, 32'd0);
    check("rstw_state", 32'(r_state), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    run_access(1'b1, 1'b1, 8'h30, 32'd0, 32'h0BADCAFE, "rstw_rd");

    // Held MFA with WAIT_CYCLES = 0.
    @(negedge Clk);
    z_rw = 1'b0; z_wb = 1'b1; z_addr = 8'h08; z_din = 32'h5A5A5A5A; z_mfa = 1'b1;
    @(posedge Clk); #1;
    check("hold_mfc_k", 32'(z_mfc), 32'd0);
    @(posedge Clk); #1;
    check("hold_mfc_k1", 32'(z_mfc), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("hold_mfc_held", 32'(z_mfc), 32'd1);
      check("hold_state_done", 32'(z_state), 32'd2);
    end
    check("hold_dout", z_dout, 32'd0);
    @(negedge Clk);
    z_mfa = 1'b0;
    @(posedge Clk); #1;
    check("hold_mfc_fall", 32'(z_mfc), 32'd0);
    check("hold_idle", 32'(z_state), 32'd0);
    @(negedge Clk);
    z_rw = 1'b1; z_addr = 8'h09; z_mfa = 1'b1;
    @(posedge Clk); #1;
    check("rearm_accept", 32'(z_state), 32'd1);
    @(posedge Clk); #1;
    check("rearm_mfc", 32'(z_mfc), 32'd1);
    check("rearm_dout", z_dout, 32'h5A5A5A5A);
    @(negedge Clk);
    z_mfa = 1'b0;
    @(posedge Clk); #1;
    check("rearm_mfc_fall", 32'(z_mfc), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
